// File: rtl/rd_ddr_pkg.sv
// Shared types and constants for the DDR frame read burst controller.
package rd_ddr_pkg;

    // Controller states, in the order a normal frame walks through them.
    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        CHECK,
        REQ,
        DATA,
        DONE
    } state_t;

    // One read beat is 256 bits.
    localparam int BEAT_BYTES   = 32;
    // Cycles the downstream FIFO is held in reset at the start of a frame.
    localparam int FLUSH_CYCLES = 4;

endpackage : rd_ddr_pkg

// File: rtl/rd_ddr_burst_ctrl.sv
// Reads one video frame from DDR as a sequence of fixed-length bursts and
// streams the beats straight into a FIFO. A burst is only requested when the
// FIFO has room for the whole burst, so r_ready never has to drop mid-burst.
// Optional feature: define RD_PINGPONG_EN to read the buffer that the capture
// side is not currently writing (base_addr1 when wr_frame_idx=0, else
// base_addr0). Without it every frame is read from base_addr0.
module rd_ddr_burst_ctrl
    import rd_ddr_pkg::*;
#(
    parameter int ADDR_W      = 28,
    parameter int BURST_LEN   = 16,
    parameter int FRAME_BEATS = 115200,
    parameter int FIFO_DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] base_addr0,
    input  logic [ADDR_W-1:0] base_addr1,
    input  logic              wr_frame_idx,
    input  logic [8:0]        wr_water_level,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] ar_addr,
    output logic [7:0]        ar_len,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [255:0]      r_data,
    input  logic              r_last,
    output logic              fifo_rst,
    output logic              fifo_wr_en,
    output logic [255:0]      fifo_wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);

    localparam int CNT_W = $clog2(FRAME_BEATS + 1);
    localparam int BB_W  = $clog2(BURST_LEN + 1);
    localparam int FC_W  = $clog2(FLUSH_CYCLES);
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * BEAT_BYTES);

    // A frame must be an exact number of bursts so no burst runs past its end.
    generate
        if (FRAME_BEATS <= 0 || (FRAME_BEATS % BURST_LEN) != 0) begin : g_bad_cfg
            $error("rd_ddr_burst_ctrl: FRAME_BEATS must be a positive multiple of BURST_LEN");
        end
    endgenerate

    state_t            state, next_state;
    logic [1:0]        rst_sync;
    logic              rst_sync_n;
    logic [FC_W-1:0]   flush_cnt;
    logic [BB_W-1:0]   burst_beat;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  beat_cnt;
    logic              pending;
    logic [ADDR_W-1:0] pend_base;
    logic              err_q;
    logic [ADDR_W-1:0] frame_base;
    logic              start_flush;
    logic              beat_hs;
    logic              last_beat;
    logic              fifo_has_room;
    logic              frame_complete;

`ifdef RD_PINGPONG_EN
    // Read the buffer opposite to the one being captured.
    assign frame_base = wr_frame_idx ? base_addr0 : base_addr1;
`else
    assign frame_base = base_addr0;
    logic unused_pingpong;
    assign unused_pingpong = ^{base_addr1, wr_frame_idx};
`endif

    assign beat_hs        = (state == DATA) && r_valid;
    assign last_beat      = (burst_beat == BB_W'(BURST_LEN - 1));
    assign fifo_has_room  = (32'(wr_water_level) + 32'(BURST_LEN)) <= 32'(FIFO_DEPTH);
    assign frame_complete = (beat_cnt == CNT_W'(FRAME_BEATS));
    assign rst_sync_n     = rst_sync[1];

    // Reset synchroniser: asserts with rst_n, releases two clocks later.
    // NOTE: the release edge is re-timed so no flop sees rst_n drop out near clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    // State register.
    // NOTE: state and counters use <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           state <= IDLE;
        else if (!rst_sync_n) state <= IDLE;
        else                  state <= next_state;
    end

    // Next-state logic; start_flush marks every entry (or re-entry) into FLUSH.
    // NOTE: both outputs get a default first so no latch is inferred.
    always_comb begin
        next_state  = state;
        start_flush = 1'b0;
        unique case (state)
            IDLE:  if (frame_start) start_flush = 1'b1;
            FLUSH: begin
                if (frame_start)                              start_flush = 1'b1;
                else if (flush_cnt == FC_W'(FLUSH_CYCLES - 1)) next_state  = CHECK;
            end
            CHECK: begin
                if (frame_start)         start_flush = 1'b1;
                else if (frame_complete) next_state  = DONE;
                else if (fifo_has_room)  next_state  = REQ;
            end
            // A handshake in the same cycle commits the burst; the restart then
            // waits as pending until the burst drains.
            REQ: begin
                if (ar_ready)         next_state  = DATA;
                else if (frame_start) start_flush = 1'b1;
            end
            DATA: begin
                if (beat_hs && last_beat) begin
                    if (pending || frame_start) start_flush = 1'b1;
                    else                        next_state  = CHECK;
                end
            end
            DONE: begin
                if (frame_start) start_flush = 1'b1;
                else             next_state  = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (start_flush) next_state = FLUSH;
    end

    // Address, beat counters, pending restart and sticky protocol error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || !rst_sync_n) begin
            flush_cnt  <= '0;
            burst_beat <= '0;
            addr       <= '0;
            beat_cnt   <= '0;
            pending    <= 1'b0;
            pend_base  <= '0;
            err_q      <= 1'b0;
        end else begin
            if (start_flush) begin
                addr       <= frame_start ? frame_base : pend_base;
                beat_cnt   <= '0;
                flush_cnt  <= '0;
                burst_beat <= '0;
                pending    <= 1'b0;
            end else begin
                if (state == FLUSH) flush_cnt <= flush_cnt + 1'b1;
                if (frame_start && (state == DATA || state == REQ)) begin
                    pending   <= 1'b1;
                    pend_base <= frame_base;
                end
                if (beat_hs) begin
                    if (last_beat) begin
                        burst_beat <= '0;
                        addr       <= addr + BURST_BYTES;
                        beat_cnt   <= beat_cnt + CNT_W'(BURST_LEN);
                    end else begin
                        burst_beat <= burst_beat + 1'b1;
                    end
                end
            end
            // The local beat count decides the burst end; r_last is only checked.
            if (beat_hs && (last_beat ? !r_last : r_last)) err_q <= 1'b1;
        end
    end

    // Moore outputs decoded from the state.
    always_comb begin
        ar_valid   = (state == REQ);
        r_ready    = (state == DATA);
        fifo_rst   = (state == FLUSH) || !rst_sync_n;
        busy       = (state != IDLE);
        frame_done = (state == DONE);
    end

    assign ar_addr      = addr;
    assign ar_len       = 8'(BURST_LEN - 1);
    assign fifo_wr_en   = r_ready && r_valid;
    assign fifo_wr_data = r_data;
    assign err          = err_q;

endmodule : rd_ddr_burst_ctrl

// File: tb/tb_rd_ddr_burst_ctrl.sv
// Directed bench for rd_ddr_burst_ctrl with a 64-beat frame (4 bursts of 16).
// Expected base follows RD_PINGPONG_EN: base_addr1 when defined (wr_frame_idx=0),
// base_addr0 otherwise.
module tb_rd_ddr_burst_ctrl;

    localparam int ADDR_W = 28;
    localparam logic [ADDR_W-1:0] BASE0 = 28'h100_0000;
    localparam logic [ADDR_W-1:0] BASE1 = 28'h200_0000;
`ifdef RD_PINGPONG_EN
    localparam logic [ADDR_W-1:0] EXP_BASE = BASE1;
`else
    localparam logic [ADDR_W-1:0] EXP_BASE = BASE0;
`endif
    localparam logic [255:0] DATA_PAT = {8{32'hDEAD_BEEF}};

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              frame_start = 1'b0;
    logic [ADDR_W-1:0] base_addr0 = BASE0;
    logic [ADDR_W-1:0] base_addr1 = BASE1;
    logic              wr_frame_idx = 1'b0;
    logic [8:0]        wr_water_level = '0;
    logic              ar_valid;
    logic              ar_ready = 1'b1;
    logic [ADDR_W-1:0] ar_addr;
    logic [7:0]        ar_len;
    logic              r_valid = 1'b1;
    logic              r_ready;
    logic [255:0]      r_data = DATA_PAT;
    logic              r_last;
    logic              fifo_rst;
    logic              fifo_wr_en;
    logic [255:0]      fifo_wr_data;
    logic              busy;
    logic              frame_done;
    logic              err;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int done_count = 0;
    int tb_beat = 0;
    int last_pos = 15;
    logic beat_taken = 1'b0;
    logic [ADDR_W-1:0] ar_q[$];

    rd_ddr_burst_ctrl #(
        .ADDR_W(ADDR_W), .BURST_LEN(16), .FRAME_BEATS(64), .FIFO_DEPTH(256)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .base_addr0(base_addr0), .base_addr1(base_addr1),
        .wr_frame_idx(wr_frame_idx), .wr_water_level(wr_water_level),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
        .fifo_rst(fifo_rst), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .busy(busy), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    // Bench-side memory model: r_last marks beat index last_pos of each burst.
    assign r_last = (tb_beat == last_pos);

    // Event monitor, sampled mid-cycle.
    always @(negedge clk) begin
        beat_taken <= fifo_wr_en;
        if (fifo_wr_en) wr_count <= wr_count + 1;
        if (ar_valid && ar_ready) ar_q.push_back(ar_addr);
        if (frame_done) done_count <= done_count + 1;
    end

    // Advance the model's beat index just after each accepted beat.
    always @(posedge clk) begin
        #1;
        if (!rst_n)          tb_beat <= 0;
        else if (beat_taken) tb_beat <= (tb_beat == 15) ? 0 : tb_beat + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target);
        for (int i = 0; i < 1000 && done_count < target; i++) tick();
        check(tag, 64'(done_count), 64'(target));
    endtask

    initial begin
        int wr0, arn0, d0;

        // ---------------- reset ----------------
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ar_valid", 64'(ar_valid), 64'd0);
        check("rst_r_ready", 64'(r_ready), 64'd0);
        check("rst_fifo_wr_en", 64'(fifo_wr_en), 64'd0);
        check("rst_fifo_rst", 64'(fifo_rst), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("idle_fifo_rst", 64'(fifo_rst), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_ar_valid", 64'(ar_valid), 64'd0);
        tick();

        // ---------------- full frame, no back-pressure ----------------
        wr0 = wr_count; arn0 = ar_q.size(); d0 = done_count;
        pulse_start();
        for (int i = 0; i < 40 && !fifo_wr_en; i++) @(negedge clk);
        check("b_first_wr_en", 64'(fifo_wr_en), 64'd1);
        check("b_wr_data_lo", fifo_wr_data[63:0], DATA_PAT[63:0]);
        check("b_wr_data_hi", fifo_wr_data[255:192], DATA_PAT[255:192]);
        check("b_ar_len", 64'(ar_len), 64'd15);
        wait_done("b_frame_done", d0 + 1);
        repeat (3) tick();
        check("b_done_once", 64'(done_count), 64'(d0 + 1));
        check("b_wr_count", 64'(wr_count - wr0), 64'd64);
        check("b_bursts", 64'(ar_q.size() - arn0), 64'd4);
        if (ar_q.size() >= arn0 + 4) begin
            check("b_addr0", 64'(ar_q[arn0]),     64'(EXP_BASE));
            check("b_addr1", 64'(ar_q[arn0 + 1]), 64'(EXP_BASE + 28'h200));
            check("b_addr2", 64'(ar_q[arn0 + 2]), 64'(EXP_BASE + 28'h400));
            check("b_addr3", 64'(ar_q[arn0 + 3]), 64'(EXP_BASE + 28'h600));
        end
        check("b_busy_end", 64'(busy), 64'd0);
        check("b_err", 64'(err), 64'd0);

        // ---------------- FIFO level threshold 241 / 240 ----------------
        arn0 = ar_q.size(); d0 = done_count;
        wr_water_level = 9'd241;
        pulse_start();
        repeat (10) tick();
        @(negedge clk);
        check("c_241_no_ar_valid", 64'(ar_valid), 64'd0);
        check("c_241_busy", 64'(busy), 64'd1);
        check("c_241_no_burst", 64'(ar_q.size() - arn0), 64'd0);
        tick();
        wr_water_level = 9'd240;
        @(negedge clk);
        check("c_240_same_cycle", 64'(ar_valid), 64'd0);
        @(negedge clk);
        check("c_240_ar_valid", 64'(ar_valid), 64'd1);
        check("c_240_ar_addr", 64'(ar_addr), 64'(EXP_BASE));
        wait_done("c_frame_done", d0 + 1);
        wr_water_level = 9'd0;
        tick();

        // ---------------- delayed ar_ready, r_valid gaps ----------------
        wr0 = wr_count; arn0 = ar_q.size(); d0 = done_count;
        ar_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 20 && !ar_valid; i++) @(negedge clk);
        check("d_ar_valid_seen", 64'(ar_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            check("d_ar_valid_held", 64'(ar_valid), 64'd1);
            check("d_ar_addr_stable", 64'(ar_addr), 64'(EXP_BASE));
            check("d_ar_len_stable", 64'(ar_len), 64'd15);
            @(negedge clk);
        end
        check("d_no_beats_before_hs", 64'(wr_count - wr0), 64'd0);
        tick();
        ar_ready = 1'b1;
        for (int i = 0; i < 1000 && done_count < d0 + 1; i++) begin
            r_valid = (i % 3 != 0);
            tick();
        end
        r_valid = 1'b1;
        check("d_frame_done", 64'(done_count), 64'(d0 + 1));
        check("d_wr_count", 64'(wr_count - wr0), 64'd64);
        check("d_bursts", 64'(ar_q.size() - arn0), 64'd4);
        if (ar_q.size() >= arn0 + 4)
            check("d_addr3", 64'(ar_q[arn0 + 3]), 64'(EXP_BASE + 28'h600));
        check("d_err", 64'(err), 64'd0);

        // ---------------- frame_start while draining a burst ----------------
        wr0 = wr_count; arn0 = ar_q.size(); d0 = done_count;
        pulse_start();
        for (int i = 0; i < 200 && (wr_count - wr0) < 20; i++) tick();
        check("e_reached_beat20", 64'((wr_count - wr0) >= 20), 64'd1);
        pulse_start();
        for (int i = 0; i < 40 && !fifo_rst; i++) @(negedge clk);
        check("e_flush_seen", 64'(fifo_rst), 64'd1);
        check("e_burst_drained", 64'(wr_count - wr0), 64'd32);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check("e_fifo_rst_held", 64'(fifo_rst), 64'd1);
        end
        @(negedge clk);
        check("e_fifo_rst_released", 64'(fifo_rst), 64'd0);
        for (int i = 0; i < 40 && ar_q.size() < arn0 + 3; i++) tick();
        check("e_bursts_before_restart", 64'(ar_q.size() >= arn0 + 3), 64'd1);
        if (ar_q.size() >= arn0 + 3)
            check("e_addr_reloaded", 64'(ar_q[arn0 + 2]), 64'(EXP_BASE));
        wait_done("e_frame_done", d0 + 1);
        check("e_wr_count", 64'(wr_count - wr0), 64'd96);

        // ---------------- early r_last on beat 8 ----------------
        wr0 = wr_count; arn0 = ar_q.size(); d0 = done_count;
        check("f_err_before", 64'(err), 64'd0);
        last_pos = 7;
        pulse_start();
        for (int i = 0; i < 200 && ar_q.size() < arn0 + 2; i++) tick();
        check("f_second_burst", 64'(ar_q.size() >= arn0 + 2), 64'd1);
        if (ar_q.size() >= arn0 + 2)
            check("f_second_addr", 64'(ar_q[arn0 + 1]), 64'(EXP_BASE + 28'h200));
        check("f_beats_first_burst", 64'(wr_count - wr0), 64'd16);
        check("f_err_set", 64'(err), 64'd1);
        wait_done("f_frame_done", d0 + 1);
        repeat (2) tick();
        check("f_err_sticky", 64'(err), 64'd1);
        check("f_wr_count", 64'(wr_count - wr0), 64'd64);
        check("f_busy_end", 64'(busy), 64'd0);
        last_pos = 15;

        // ---------------- reset in the middle of a burst ----------------
        wr0 = wr_count;
        pulse_start();
        for (int i = 0; i < 200 && (wr_count - wr0) < 5; i++) tick();
        check("g_mid_burst_r_ready", 64'(r_ready), 64'd1);
        rst_n = 1'b0;
        #1;
        check("g_rst_ar_valid", 64'(ar_valid), 64'd0);
        check("g_rst_r_ready", 64'(r_ready), 64'd0);
        check("g_rst_fifo_wr_en", 64'(fifo_wr_en), 64'd0);
        check("g_rst_fifo_rst", 64'(fifo_rst), 64'd1);
        check("g_rst_busy", 64'(busy), 64'd0);
        check("g_rst_frame_done", 64'(frame_done), 64'd0);
        check("g_rst_err", 64'(err), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("g_idle_after_release", 64'(busy), 64'd0);
        check("g_fifo_rst_after_release", 64'(fifo_rst), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rd_ddr_burst_ctrl

// File: doc/rd_ddr_burst_ctrl.md
RD_DDR_BURST_CTRL -- requirements
Module: rd_ddr_burst_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 28, meaning DDR byte-address width.
REQ-002 The block SHALL have parameter BURST_LEN, default 16, meaning 256-bit beats per read burst.
REQ-003 The block SHALL have parameter FRAME_BEATS, default 115200, meaning 256-bit beats per frame (1280x720x32b).
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 256, meaning read FIFO write-side depth in 256-bit words.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, the DDR user clock. Already decided.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low. Already decided.
REQ-007 The block SHALL have port frame_start, input, 1 bit: one-cycle pulse that starts a new frame read.
REQ-008 The block SHALL have port base_addr0, input, ADDR_W bits: frame buffer 0 base address.
REQ-009 The block SHALL have port base_addr1, input, ADDR_W bits: frame buffer 1 base address.
REQ-010 The block SHALL have port wr_frame_idx, input, 1 bit: buffer currently being written by the capture side.
REQ-011 The block SHALL have port wr_water_level, input, 9 bits: FIFO write-side fill level.
REQ-012 The block SHALL have ports ar_valid out 1, ar_ready in 1, ar_addr out ADDR_W, ar_len out 8: read-address handshake.
REQ-013 The block SHALL have ports r_valid in 1, r_ready out 1, r_data in 256, r_last in 1: read-data channel.
REQ-014 The block SHALL have ports fifo_rst out 1, fifo_wr_en out 1, fifo_wr_data out 256: FIFO write side.
REQ-015 The block SHALL have status outputs busy 1, frame_done 1 (pulse) and err 1 (sticky).

Function
REQ-016 The state machine SHALL have states IDLE, FLUSH, CHECK, REQ, DATA and DONE.
REQ-017 On frame_start in any state, the block SHALL enter FLUSH, assert fifo_rst for 4 cycles, load addr=base, beat_cnt=0, then enter CHECK.
REQ-018 In CHECK, the block SHALL go to REQ when wr_water_level + BURST_LEN <= FIFO_DEPTH and to DONE when beat_cnt == FRAME_BEATS; otherwise it stays in CHECK.
REQ-019 In REQ, ar_valid=1, ar_addr=addr, ar_len=BURST_LEN-1; ar_addr and ar_len SHALL stay stable until ar_ready; on ar_valid&ar_ready the block enters DATA.
REQ-020 Only one burst SHALL be outstanding at a time.
REQ-021 In DATA, r_ready=1; fifo_wr_en SHALL equal r_valid&r_ready combinationally, and fifo_wr_data SHALL equal r_data (zero latency).
REQ-022 The block SHALL count beats per burst; at the BURST_LEN-th beat it SHALL set addr += BURST_LEN*32 and beat_cnt += BURST_LEN, then return to CHECK.
REQ-023 If r_last is high before the last beat, or low on the last beat, the block SHALL set err; burst length counting SHALL remain authoritative.
REQ-024 The block SHALL NOT issue a burst that crosses FRAME_BEATS; FRAME_BEATS SHALL be a multiple of BURST_LEN (elaboration check).
REQ-025 DONE SHALL pulse frame_done for 1 cycle, then the block enters IDLE.
REQ-026 busy SHALL be 1 in all states except IDLE.
REQ-027 frame_start during DATA SHALL take effect only after the current burst drains (ar/r protocol is never abandoned); frame_start in any other state SHALL take effect immediately.
REQ-028 frame_start received while draining SHALL be latched as pending; further pulses SHALL merge into it.

Reset
REQ-029 While rst_n=0, the block SHALL be in IDLE with ar_valid=0, r_ready=0, fifo_wr_en=0, fifo_rst=1, busy=0, frame_done=0, err=0, addr=0 and beat_cnt=0.
REQ-030 Reset deassertion SHALL be synchronised internally (asynchronous assert, synchronous release); the first action after reset SHALL be waiting in IDLE for frame_start.

Configuration
REQ-031 With RD_PINGPONG_EN defined, the frame base SHALL be base_addr1 when wr_frame_idx=0 and base_addr0 otherwise, sampled at frame_start.
REQ-032 Without RD_PINGPONG_EN, the frame base SHALL always be base_addr0; base_addr1 and wr_frame_idx SHALL be unused.

Structure
REQ-033 Package rd_ddr_pkg SHALL hold the state enum, BEAT_BYTES=32 and the FLUSH_CYCLES=4 constant.
REQ-034 No sub-module is needed; the FSM, address counter and beat counter SHALL reside in rd_ddr_burst_ctrl.

Verification
REQ-035 Test: FRAME_BEATS=64, level=0, ar_ready=1, r_valid=1 -> 4 bursts at base, +0x200, +0x400, +0x600, 64 fifo_wr_en, 1 frame_done.
REQ-036 Test: level held at 241 -> no ar_valid; level drops to 240 -> ar_valid on the next cycle.
REQ-037 Test: ar_ready delayed 5 cycles -> ar_addr and ar_len stable throughout; r_valid gaps -> beat count unaffected.
REQ-038 Test: r_last on beat 8 -> err=1 and stays 1; burst still ends after 16 beats.
REQ-039 Test: frame_start mid-DATA -> remaining beats complete, then fifo_rst for 4 cycles and addr reloaded to base.
REQ-040 Test: with RD_PINGPONG_EN and wr_frame_idx=0 -> first ar_addr=base_addr1; rst_n low mid-burst -> all outputs return to their reset values immediately.
